axi_lite_a32_d32_req_arbiter: RTL

- Shares one AXI-Lite (32-bit addr, 32-bit data) master port among NUM_REQ upstream requesters.
- The master port feeds the AXI-Lite master-side logic-link adapter.
- Read and write directions are arbitrated independently, round-robin, with one outstanding transaction per direction.
- Each response is routed back to the requester that issued the transaction.

---
 rtl/axi_lite_a32_d32_req_arbiter.sv | 192 +++++++++++++++++++
 1 files changed

// File: rtl/axi_lite_a32_d32_req_arbiter.sv
// Shares one AXI-Lite (A32/D32) master port among NUM_REQ requesters.
// Reads and writes are arbitrated independently, round-robin, with one outstanding transaction each.
module axi_lite_a32_d32_req_arbiter #(
    parameter  int NUM_REQ = 2,
    localparam int GW      = $clog2(NUM_REQ)
) (
    input  logic                 clk_wr,
    input  logic                 rst_wr_n,
    input  logic [NUM_REQ*32-1:0] s_araddr,
    input  logic [NUM_REQ-1:0]    s_arvalid,
    output logic [NUM_REQ-1:0]    s_arready,
    input  logic [NUM_REQ*32-1:0] s_awaddr,
    input  logic [NUM_REQ-1:0]    s_awvalid,
    output logic [NUM_REQ-1:0]    s_awready,
    input  logic [NUM_REQ*32-1:0] s_wdata,
    input  logic [NUM_REQ*4-1:0]  s_wstrb,
    input  logic [NUM_REQ-1:0]    s_wvalid,
    output logic [NUM_REQ-1:0]    s_wready,
    output logic [NUM_REQ*32-1:0] s_rdata,
    output logic [NUM_REQ*2-1:0]  s_rresp,
    output logic [NUM_REQ-1:0]    s_rvalid,
    input  logic [NUM_REQ-1:0]    s_rready,
    output logic [NUM_REQ*2-1:0]  s_bresp,
    output logic [NUM_REQ-1:0]    s_bvalid,
    input  logic [NUM_REQ-1:0]    s_bready,
    output logic [31:0]           m_araddr,
    output logic                  m_arvalid,
    input  logic                  m_arready,
    output logic [31:0]           m_awaddr,
    output logic                  m_awvalid,
    input  logic                  m_awready,
    output logic [31:0]           m_wdata,
    output logic [3:0]            m_wstrb,
    output logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic [31:0]           m_rdata,
    input  logic [1:0]            m_rresp,
    input  logic                  m_rvalid,
    output logic                  m_rready,
    input  logic [1:0]            m_bresp,
    input  logic                  m_bvalid,
    output logic                  m_bready,
    output logic                  rd_busy,
    output logic                  wr_busy,
    output logic [GW-1:0]         rd_gnt,
    output logic [GW-1:0]         wr_gnt
);

    typedef enum logic [1:0] {R_IDLE, R_ADDR, R_RESP} rd_state_t;
    typedef enum logic [1:0] {W_IDLE, W_ADDR, W_RESP} wr_state_t;

    rd_state_t     rd_state, rd_state_nxt;
    wr_state_t     wr_state, wr_state_nxt;
    logic [GW-1:0] rd_ptr, rd_ptr_nxt, rd_gnt_nxt;
    logic [GW-1:0] wr_ptr, wr_ptr_nxt, wr_gnt_nxt;
    logic          aw_done, aw_done_nxt;
    logic          w_done, w_done_nxt;

    // First set request at or after ptr, wrapping; scanning downward lets the smallest offset win.
    function automatic logic [GW-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                              input logic [GW-1:0] ptr);
        logic [GW-1:0] pick;
        int            idx;
        pick = ptr;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = int'(ptr) + k;
            if (idx >= NUM_REQ) idx -= NUM_REQ;
            if (req[idx]) pick = GW'(idx);
        end
        return pick;
    endfunction

    function automatic logic [GW-1:0] gnt_inc(input logic [GW-1:0] g);
        return (g == GW'(NUM_REQ - 1)) ? '0 : g + GW'(1);
    endfunction

    // Responses are broadcast; only the granted requester sees valid.
    assign s_rdata = {NUM_REQ{m_rdata}};
    assign s_rresp = {NUM_REQ{m_rresp}};
    assign s_bresp = {NUM_REQ{m_bresp}};

    assign m_araddr = s_araddr[int'(rd_gnt)*32 +: 32];
    assign m_awaddr = s_awaddr[int'(wr_gnt)*32 +: 32];
    assign m_wdata  = s_wdata[int'(wr_gnt)*32 +: 32];
    assign m_wstrb  = s_wstrb[int'(wr_gnt)*4 +: 4];

    assign rd_busy = (rd_state != R_IDLE);
    assign wr_busy = (wr_state != W_IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no path can infer a latch.
        rd_state_nxt = rd_state;
        rd_gnt_nxt   = rd_gnt;
        rd_ptr_nxt   = rd_ptr;
        m_arvalid    = 1'b0;
        s_arready    = '0;
        s_rvalid     = '0;
        m_rready     = 1'b0;
        unique case (rd_state)
            R_IDLE: begin
                if (|s_arvalid) begin
                    rd_gnt_nxt   = rr_pick(s_arvalid, rd_ptr);
                    rd_state_nxt = R_ADDR;
                end
            end
            R_ADDR: begin
                m_arvalid         = s_arvalid[rd_gnt];
                s_arready[rd_gnt] = m_arready;
                if (m_arvalid && m_arready) rd_state_nxt = R_RESP;
            end
            R_RESP: begin
                s_rvalid[rd_gnt] = m_rvalid;
                m_rready         = s_rready[rd_gnt];
                if (m_rvalid && m_rready) begin
                    rd_state_nxt = R_IDLE;
                    rd_ptr_nxt   = gnt_inc(rd_gnt);
                end
            end
            default: rd_state_nxt = R_IDLE;
        endcase
    end

    always_comb begin
        wr_state_nxt = wr_state;
        wr_gnt_nxt   = wr_gnt;
        wr_ptr_nxt   = wr_ptr;
        aw_done_nxt  = aw_done;
        w_done_nxt   = w_done;
        m_awvalid    = 1'b0;
        m_wvalid     = 1'b0;
        s_awready    = '0;
        s_wready     = '0;
        s_bvalid     = '0;
        m_bready     = 1'b0;
        unique case (wr_state)
            W_IDLE: begin
                // Only AW requests a grant; early W data waits at the requester.
                if (|s_awvalid) begin
                    wr_gnt_nxt   = rr_pick(s_awvalid, wr_ptr);
                    wr_state_nxt = W_ADDR;
                end
            end
            W_ADDR: begin
                m_awvalid         = s_awvalid[wr_gnt] & ~aw_done;
                s_awready[wr_gnt] = m_awready & ~aw_done;
                m_wvalid          = s_wvalid[wr_gnt] & ~w_done;
                s_wready[wr_gnt]  = m_wready & ~w_done;
                if ((aw_done || (m_awvalid && m_awready)) && (w_done || (m_wvalid && m_wready))) begin
                    wr_state_nxt = W_RESP;
                    aw_done_nxt  = 1'b0;
                    w_done_nxt   = 1'b0;
                end else begin
                    aw_done_nxt = aw_done | (m_awvalid & m_awready);
                    w_done_nxt  = w_done | (m_wvalid & m_wready);
                end
            end
            W_RESP: begin
                s_bvalid[wr_gnt] = m_bvalid;
                m_bready         = s_bready[wr_gnt];
                if (m_bvalid && m_bready) begin
                    wr_state_nxt = W_IDLE;
                    wr_ptr_nxt   = gnt_inc(wr_gnt);
                end
            end
            default: wr_state_nxt = W_IDLE;
        endcase
    end

    always_ff @(posedge clk_wr or negedge rst_wr_n) begin
        if (!rst_wr_n) begin
            rd_state <= R_IDLE;
            wr_state <= W_IDLE;
            rd_gnt   <= '0;
            wr_gnt   <= '0;
            rd_ptr   <= '0;
            wr_ptr   <= '0;
            aw_done  <= 1'b0;
            w_done   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments so every register samples pre-edge values.
            rd_state <= rd_state_nxt;
            wr_state <= wr_state_nxt;
            rd_gnt   <= rd_gnt_nxt;
            wr_gnt   <= wr_gnt_nxt;
            rd_ptr   <= rd_ptr_nxt;
            wr_ptr   <= wr_ptr_nxt;
            aw_done  <= aw_done_nxt;
            w_done   <= w_done_nxt;
        end
    end

endmodule
